rr_arbiter_request_client: RTL and testbench
============================================

// Module: rr_arbiter_request_client
// PURPOSE
//  Requester-side agent for the 2-request round-robin arbiter: one instance per client.
//  Buffers client transactions in a small FIFO and raises request while data is pending.
//  Drives the shared bus while granted, and pops one entry per granted cycle.
//  Monitors fairness with a wait counter and starvation flag, and flags protocol violations.
//  Sits between a client's valid/ready source and one requests[i]/grants[i] pair.
// PARAMETERS
//  DATA_W    8  width of transaction payload
//  DEPTH     4  FIFO entries; power of 2, >= 2
//  WAIT_W    4  width of wait counter (saturating)
//  MAX_WAIT  8  wait_cnt value at/above which starved asserts; 1 <= MAX_WAIT <= 2**WAIT_W-1
// PORTS
//  clk        in   1                    clock, all state on posedge
//  rst        in   1                    reset, synchronous, active-high
//  in_valid   in   1                    client offers in_data
//  in_ready   out  1                    FIFO can accept (push when in_valid & in_ready)
//  in_data    in   DATA_W               client payload
//  request    out  1                    to arbiter requests[i]; high while FIFO non-empty
//  grant      in   1                    from arbiter grants[i]; same-cycle response to request
//  bus_valid  out  1                    grant & request: bus_data is valid this cycle
//  bus_data   out  DATA_W               FIFO head when bus_valid, else 0
//  level      out  $clog2(DEPTH)+1      current FIFO occupancy
//  wait_cnt   out  WAIT_W               consecutive cycles requested but not granted
//  starved    out  1                    wait_cnt >= MAX_WAIT
//  grant_err  out  1                    sticky: grant seen while request low
// BEHAVIOUR
//  Reset: FIFO emptied, rd/wr ptrs=0, level=0, wait_cnt=0, grant_err=0.
//   After reset: request=0, in_ready=1, bus_valid=0, bus_data=0, starved=0.
//  Reset mid-operation discards all buffered entries; no bus output until new pushes.
//  request = (level != 0). It is a pure function of registered state: no combinational
//   path from grant or in_valid. Accept-to-request latency is 1 cycle.
//  in_ready = (level != DEPTH). It is registered-state only: when full, in_ready stays 0
//   even in a pop cycle, and rises the cycle after the pop.
//  Push: in_valid & in_ready writes in_data at wr_ptr, and wr_ptr wraps modulo DEPTH.
//  Pop: bus_valid at the clock edge advances rd_ptr, which wraps modulo DEPTH.
//   Push and pop in the same cycle leave level unchanged.
//  bus_valid/bus_data are combinational from grant and registered state.
//   One entry is delivered per granted cycle, in FIFO order, with no duplication or loss.
//  wait_cnt next-state:
//   request & ~grant -> wait_cnt+1, saturating at 2**WAIT_W-1.
//   otherwise (granted, or not requesting) -> 0.
//  starved is decoded from registered wait_cnt. It clears the cycle after any grant.
//  grant_err is set on the edge where grant & ~request, and is cleared only by rst.
//   A grant while empty never pops: level and pointers are unchanged.
//  Arbiter contract: grant is only meaningful while request is high. Request stays high
//   across consecutive grants while level > 0; the client never withdraws a pending request.
// TESTING
//  1 Reset: rst high 2 cycles, then low -> request=0, in_ready=1, level=0, bus_valid=0,
//    wait_cnt=0, grant_err=0.
//  2 Stream: push 0x11,0x22,0x33 on cycles 0-2, grant=1 held -> request rises cycle 1;
//    bus_data=0x11,0x22,0x33 on cycles 1,2,3; level returns to 0 and request=0 at cycle 4.
//  3 Full: grant=0, push 4 entries -> level=4, in_ready=0; a 5th in_valid (0x55) is ignored.
//    grant=1 for 1 cycle -> pops the head; in_ready=0 that cycle and 1 the next; level=3.
//  4 Starvation: 1 entry, grant=0 for 10 cycles -> wait_cnt 1..10; starved from wait_cnt=8;
//    grant=1 for 1 cycle -> entry popped, then wait_cnt=0 and starved=0.
//  5 Protocol error: empty FIFO, grant=1 for 1 cycle -> bus_valid=0, level stays 0,
//    grant_err=1 from next cycle and sticky; rst clears it.
//  6 System: two instances on the 2-request round-robin arbiter, each preloaded with 3
//    entries (A0..A2, B0..B2) -> bus sequence B0,A0,B1,A1,B2,A2 after reset;
//    starved never asserts and wait_cnt <= 1 throughout.

Source files
------------

// File: rtl/rr_arbiter_request_client.sv
// Requester-side agent for a 2-way round-robin arbiter.
// Buffers client data, requests while non-empty, drives the bus on grant.
module rr_arbiter_request_client #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       request,
  input  logic                       grant,
  output logic                       bus_valid,
  output logic [DATA_W-1:0]          bus_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [WAIT_W-1:0]          wait_cnt,
  output logic                       starved,
  output logic                       grant_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_SAT = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_TH  = WAIT_W'(MAX_WAIT);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  // Handshake outputs depend only on registered occupancy.
  assign request   = (level != '0);
  assign in_ready  = (level != FULL_LVL);
  assign bus_valid = grant & request;
  assign bus_data  = bus_valid ? mem[rd_ptr] : '0;
  assign starved   = (wait_cnt >= WAIT_TH);

  assign push = in_valid & in_ready;
  assign pop  = bus_valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      grant_err <= 1'b0;
    end else begin
      if (request && !grant) begin
        if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (grant && !request) grant_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_request_client.sv
// Vector-table bench for rr_arbiter_request_client plus a
// two-client round-robin system sequence.
module tb_rr_arbiter_request_client;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       request;
  logic       grant;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic [2:0] level;
  logic [3:0] wait_cnt;
  logic       starved;
  logic       grant_err;

  rr_arbiter_request_client #(
    .DATA_W(8), .DEPTH(4), .WAIT_W(4), .MAX_WAIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .request(request), .grant(grant),
    .bus_valid(bus_valid), .bus_data(bus_data),
    .level(level), .wait_cnt(wait_cnt),
    .starved(starved), .grant_err(grant_err)
  );

  // two-client system
  logic       srst;
  logic [1:0] s_iv, s_rdy, s_req, s_gnt, s_bv, s_st, s_ge;
  logic [7:0] s_d [2];
  logic [7:0] s_bd [2];
  logic [2:0] s_lvl [2];
  logic [3:0] s_wc [2];
  logic       last;

  for (genvar i = 0; i < 2; i++) begin : g_cl
    rr_arbiter_request_client #(
      .DATA_W(8), .DEPTH(4), .WAIT_W(4), .MAX_WAIT(8)
    ) u_cl (
      .clk(clk), .rst(srst),
      .in_valid(s_iv[i]), .in_ready(s_rdy[i]), .in_data(s_d[i]),
      .request(s_req[i]), .grant(s_gnt[i]),
      .bus_valid(s_bv[i]), .bus_data(s_bd[i]),
      .level(s_lvl[i]), .wait_cnt(s_wc[i]),
      .starved(s_st[i]), .grant_err(s_ge[i])
    );
  end

  // reference round-robin arbiter: priority to the client not granted last
  always_comb begin
    s_gnt = 2'b00;
    if (s_req == 2'b11) s_gnt = last ? 2'b01 : 2'b10;
    else                s_gnt = s_req;
  end

  always_ff @(posedge clk) begin
    if (srst)          last <= 1'b0;
    else if (s_gnt[0]) last <= 1'b0;
    else if (s_gnt[1]) last <= 1'b1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        iv;
    logic [7:0]  d;
    logic        g;
    logic        chk;
    logic [19:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_bad;

  task automatic add(input logic r, iv, input logic [7:0] d,
                     input logic g, c, rq, rd, bv,
                     input logic [7:0] bd, input logic [2:0] lv,
                     input logic [3:0] wc, input logic st, ge);
    vec_t v;
    v.r = r; v.iv = iv; v.d = d; v.g = g; v.chk = c;
    v.exp = {rq, rd, bv, bd, lv, wc, st, ge};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  logic [7:0] exp_seq [6];
  logic [7:0] got;
  int         n_got;
  int         viol;

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; grant = 1'b0;
    srst = 1'b1; s_iv = '0; s_d[0] = '0; s_d[1] = '0;

    // reset
    add(1,0,8'h00,0,0, 0,1,0,8'h00,0,0,0,0);
    add(1,0,8'h00,0,1, 0,1,0,8'h00,0,0,0,0);
    add(0,0,8'h00,0,1, 0,1,0,8'h00,0,0,0,0);
    // stream with grant held
    add(0,1,8'h11,0,1, 0,1,0,8'h00,0,0,0,0);
    add(0,1,8'h22,1,1, 1,1,1,8'h11,1,0,0,0);
    add(0,1,8'h33,1,1, 1,1,1,8'h22,1,0,0,0);
    add(0,0,8'h00,1,1, 1,1,1,8'h33,1,0,0,0);
    add(0,0,8'h00,0,1, 0,1,0,8'h00,0,0,0,0);
    // fill, overflow attempts, single pop, drain
    add(0,1,8'h41,0,1, 0,1,0,8'h00,0,0,0,0);
    add(0,1,8'h42,0,1, 1,1,0,8'h00,1,0,0,0);
    add(0,1,8'h43,0,1, 1,1,0,8'h00,2,1,0,0);
    add(0,1,8'h44,0,1, 1,1,0,8'h00,3,2,0,0);
    add(0,1,8'h55,0,1, 1,0,0,8'h00,4,3,0,0);
    add(0,1,8'h56,1,1, 1,0,1,8'h41,4,4,0,0);
    add(0,0,8'h00,0,1, 1,1,0,8'h00,3,0,0,0);
    add(0,0,8'h00,1,1, 1,1,1,8'h42,3,1,0,0);
    add(0,0,8'h00,1,1, 1,1,1,8'h43,2,0,0,0);
    add(0,0,8'h00,1,1, 1,1,1,8'h44,1,0,0,0);
    add(0,0,8'h00,0,1, 0,1,0,8'h00,0,0,0,0);
    // starvation and saturation
    add(0,1,8'h66,0,1, 0,1,0,8'h00,0,0,0,0);
    for (int k = 0; k < 17; k++)
      add(0,0,8'h00,0,1, 1,1,0,8'h00,1,
          (k > 15) ? 4'd15 : 4'(k), (k >= 8), 0);
    add(0,0,8'h00,1,1, 1,1,1,8'h66,1,15,1,0);
    add(0,0,8'h00,0,1, 0,1,0,8'h00,0,0,0,0);
    // grant while empty
    add(0,0,8'h00,1,1, 0,1,0,8'h00,0,0,0,0);
    add(0,0,8'h00,0,1, 0,1,0,8'h00,0,0,0,1);
    add(0,1,8'h70,0,1, 0,1,0,8'h00,0,0,0,1);
    add(0,0,8'h00,1,1, 1,1,1,8'h70,1,0,0,1);
    add(0,0,8'h00,0,1, 0,1,0,8'h00,0,0,0,1);
    // reset with data buffered
    add(0,1,8'h77,0,1, 0,1,0,8'h00,0,0,0,1);
    add(0,1,8'h78,0,1, 1,1,0,8'h00,1,0,0,1);
    add(1,1,8'h79,0,1, 1,1,0,8'h00,2,1,0,1);
    add(0,0,8'h00,0,1, 0,1,0,8'h00,0,0,0,0);
    add(0,1,8'h7A,0,1, 0,1,0,8'h00,0,0,0,0);
    add(0,0,8'h00,1,1, 1,1,1,8'h7A,1,0,0,0);
    add(0,0,8'h00,0,1, 0,1,0,8'h00,0,0,0,0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].r; in_valid = vq[i].iv;
      in_data = vq[i].d; grant = vq[i].g;
      #1;
      if (vq[i].chk)
        check($sformatf("vec%0d", i),
              32'({request, in_ready, bus_valid, bus_data,
                   level, wait_cnt, starved, grant_err}),
              32'(vq[i].exp));
    end

    // system: two clients through the round-robin arbiter
    exp_seq = '{8'hB0, 8'hA0, 8'hB1, 8'hA1, 8'hB2, 8'hA2};
    @(negedge clk); srst = 1'b1;
    @(negedge clk); srst = 1'b1;
    n_got = 0; viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      srst = 1'b0;
      s_iv = (c < 3) ? 2'b11 : 2'b00;
      s_d[0] = 8'hA0 + 8'(c);
      s_d[1] = 8'hB0 + 8'(c);
      #1;
      if (s_st != 2'b00 || s_wc[0] > 4'd1 || s_wc[1] > 4'd1 ||
          s_bv == 2'b11 || s_ge != 2'b00)
        viol++;
      if (s_bv != 2'b00) begin
        got = s_bv[0] ? s_bd[0] : s_bd[1];
        if (n_got < 6)
          check($sformatf("sys_bus%0d", n_got), 32'(got),
                32'(exp_seq[n_got]));
        n_got++;
      end
    end
    check("sys_count", 32'(n_got), 32'd6);
    check("sys_fair", 32'(viol), 32'd0);
    check("sys_empty", 32'({s_lvl[0], s_lvl[1], s_req}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
